// File: rtl/pe_conv_mac.sv
// pe_conv_mac: 3-tap 1-D convolution PE producing three saturated partial sums per 5-pixel window
module pe_conv_mac #(
  parameter int DWIDTH     = 8,
  parameter int PSUM_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [5*DWIDTH-1:0]     pix_data,
  input  logic                    filt_valid,
  output logic                    filt_ready,
  input  logic [3*DWIDTH-1:0]     filt_data,
  output logic                    psum_valid,
  input  logic                    psum_ready,
  output logic [PSUM_WIDTH-1:0]   psum_data,
  output logic [1:0]              psum_idx,
  output logic                    busy
);
  localparam int AW = 2*DWIDTH+2;
  localparam logic [AW-1:0] PMAX = AW'((64'd1 << PSUM_WIDTH) - 64'd1);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_n;
  logic filt_loaded, pix_acc, filt_acc;
  logic [DWIDTH-1:0] pix [5];
  logic [DWIDTH-1:0] filt [3];
  logic [1:0] pos, tap;
  logic [2:0] pidx;
  logic [AW-1:0] acc, sum;
  assign filt_ready = state == IDLE;
  assign pix_ready  = state == IDLE && filt_loaded;
  assign filt_acc   = filt_valid && filt_ready;
  assign pix_acc    = pix_valid && pix_ready;
  assign psum_valid = state == OUT;
  assign busy       = state != IDLE;
  assign pidx       = {1'b0, pos} + {1'b0, tap};
  // one tap product added to the running accumulator
  always_comb begin
    sum = acc + AW'(pix[pidx]) * AW'(filt[tap]);
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next state: accept window, walk three taps, hold output until taken
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pix_acc ? MAC : IDLE;
      MAC:     state_n = tap == 2'd2 ? OUT : MAC;
      OUT:     state_n = psum_ready ? (pos == 2'd2 ? IDLE : MAC) : OUT;
      default: state_n = IDLE;
    endcase
  end
  // operand storage; contents are don't-care until the matching load flag/state says otherwise
  always_ff @(posedge clk) begin
    if (filt_acc) for (int i = 0; i < 3; i++) filt[i] <= filt_data[DWIDTH*i +: DWIDTH];
    if (pix_acc) for (int i = 0; i < 5; i++) pix[i] <= pix_data[DWIDTH*i +: DWIDTH];
  end
  // position/tap counters, accumulator and registered saturated result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_loaded <= 1'b0;
      pos         <= '0;
      tap         <= '0;
      acc         <= '0;
      psum_data   <= '0;
      psum_idx    <= '0;
    end else begin
      if (filt_acc) filt_loaded <= 1'b1;
      if (pix_acc) begin
        pos <= '0;
        tap <= '0;
        acc <= '0;
      end
      if (state == MAC) begin
        acc <= sum;
        tap <= tap == 2'd2 ? 2'd0 : tap + 2'd1;
        if (tap == 2'd2) begin
          psum_data <= sum > PMAX ? {PSUM_WIDTH{1'b1}} : sum[PSUM_WIDTH-1:0];
          psum_idx  <= pos;
        end
      end
      if (state == OUT && psum_ready && pos != 2'd2) begin
        pos <= pos + 2'd1;
        tap <= '0;
        acc <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pe_conv_mac.sv
// tb_pe_conv_mac: directed bench with a window-level psum model and a per-cycle output checker
module tb_pe_conv_mac;
  logic clk = 0, rst_n = 0;
  logic pix_valid = 0, filt_valid = 0, psum_ready = 1;
  logic pix_ready, filt_ready, psum_valid, busy;
  logic [39:0] pix_data = '0;
  logic [23:0] filt_data = '0;
  logic [7:0] psum_data;
  logic [1:0] psum_idx;
  typedef struct { int data; int idx; } exp_t;
  exp_t q[$];
  int seen[$];
  logic [23:0] mf = '0;
  int checks = 0, errors = 0;

  pe_conv_mac dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_data(psum_data), .psum_idx(psum_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_psum(logic [23:0] f, logic [39:0] p, int k);
    int s = 0;
    for (int j = 0; j < 3; j++) s += int'(p[8*(k+j) +: 8]) * int'(f[8*j +: 8]);
    return s > 255 ? 255 : s;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // compares every valid psum against the oldest expected one
  always @(negedge clk) begin
    if (rst_n && psum_valid) begin
      if (q.size() == 0) chk("unexpected_psum", 1, 0);
      else begin
        chk("psum_data", 32'(psum_data), 32'(q[0].data));
        chk("psum_idx", 32'(psum_idx), 32'(q[0].idx));
        if (psum_ready) begin
          seen.push_back(int'(psum_data));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step;
    logic fa, pa, rs;
    fa = filt_valid && filt_ready;
    pa = pix_valid && pix_ready;
    rs = !rst_n;
    @(posedge clk);
    if (rs) q.delete();
    else begin
      if (fa) mf = filt_data;
      if (pa) for (int k = 0; k < 3; k++) q.push_back('{exp_psum(mf, pix_data, k), k});
    end
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0;
    step;
    rst_n = 1;
  endtask

  task automatic load_filt(logic [23:0] f);
    filt_valid = 1; filt_data = f;
    step;
    filt_valid = 0;
  endtask

  task automatic send_pix(logic [39:0] p);
    pix_valid = 1; pix_data = p;
    step;
    pix_valid = 0;
  endtask

  task automatic drain;
    int n = 0;
    while (busy && n < 60) begin step; n++; end
    chk("drain_timeout", 32'(busy), 0);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    step;
    step;
    chk("rst_psum_valid", 32'(psum_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pix_ready", 32'(pix_ready), 0);
    chk("rst_filt_ready", 32'(filt_ready), 1);
    chk("rst_psum_data", 32'(psum_data), 0);
    rst_n = 1;
    // basic window with unit taps and latency
    load_filt(24'h010101);
    chk("pix_ready_loaded", 32'(pix_ready), 1);
    seen.delete();
    send_pix(40'h0504030201);
    chk("busy_after_accept", 32'(busy), 1);
    step; step;
    chk("valid_e2", 32'(psum_valid), 0);
    step;
    chk("valid_e3", 32'(psum_valid), 1);
    chk("lit_p0", 32'(psum_data), 6);
    chk("lit_i0", 32'(psum_idx), 0);
    repeat (4) step;
    chk("valid_e7", 32'(psum_valid), 1);
    chk("lit_p1", 32'(psum_data), 9);
    chk("lit_i1", 32'(psum_idx), 1);
    repeat (4) step;
    chk("valid_e11", 32'(psum_valid), 1);
    chk("lit_p2", 32'(psum_data), 12);
    chk("lit_i2", 32'(psum_idx), 2);
    step;
    chk("busy_e12", 32'(busy), 0);
    chk("pix_ready_e12", 32'(pix_ready), 1);
    chk("seen_count1", seen.size(), 3);
    // saturation
    load_filt(24'hFFFFFF);
    seen.delete();
    send_pix(40'hFFFFFFFFFF);
    drain;
    chk("sat_count", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("sat_lit", seen[i], 255);
    // backpressure during idx1
    load_filt(24'h010101);
    send_pix(40'h0504030201);
    repeat (4) step;
    psum_ready = 0;
    repeat (3) step;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(psum_valid), 1);
      chk("stall_data", 32'(psum_data), 9);
      chk("stall_idx", 32'(psum_idx), 1);
      chk("stall_pix_ready", 32'(pix_ready), 0);
      chk("stall_filt_ready", 32'(filt_ready), 0);
      step;
    end
    psum_ready = 1;
    drain;
    // pixel offered with no filter loaded
    do_reset;
    pix_valid = 1; pix_data = 40'h0504030201;
    for (int i = 0; i < 3; i++) begin
      chk("nofilt_pix_ready", 32'(pix_ready), 0);
      chk("nofilt_busy", 32'(busy), 0);
      step;
    end
    filt_valid = 1; filt_data = 24'h010101;
    step;
    filt_valid = 0;
    chk("late_pix_ready", 32'(pix_ready), 1);
    step;
    pix_valid = 0;
    chk("late_accept_busy", 32'(busy), 1);
    drain;
    // filter and pixel on the same edge use the new filter
    seen.delete();
    filt_valid = 1; filt_data = 24'h020202;
    pix_valid = 1; pix_data = 40'h0504030201;
    chk("same_filt_ready", 32'(filt_ready), 1);
    chk("same_pix_ready", 32'(pix_ready), 1);
    step;
    filt_valid = 0; pix_valid = 0;
    drain;
    chk("same_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("same_p0", seen[0], 12);
      chk("same_p1", seen[1], 18);
      chk("same_p2", seen[2], 24);
    end
    // reset during the second MAC cycle
    load_filt(24'h010101);
    send_pix(40'h0504030201);
    step;
    rst_n = 0;
    step;
    rst_n = 1;
    chk("mrst_valid", 32'(psum_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_pix_ready", 32'(pix_ready), 0);
    chk("mrst_filt_ready", 32'(filt_ready), 1);
    pix_valid = 1; pix_data = 40'h0504030201;
    for (int i = 0; i < 12; i++) begin
      chk("mrst_idle", 32'(busy), 0);
      step;
    end
    pix_valid = 0;
    seen.delete();
    load_filt(24'h010101);
    send_pix(40'h0504030201);
    drain;
    chk("mrst_count", seen.size(), 3);
    if (seen.size() == 3) chk("mrst_p2", seen[2], 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
